sram_port_arbiter: RTL and testbench

- Shares the single read/write port (port 0) of one sky130 1rw1r 32x256 SRAM macro between two requesters.
- Requester A is the programming path (ICCM loader writes and debug reads); it has priority.
- Requester B is the TL-UL memory adapter (the fetch/load-store path).
- Drives the macro's active-low chip-select, write-enable and mask pins, and routes the one-cycle-late read data back to whichever requester issued the read.

---
 rtl/sram_port_arbiter_if.sv | 56 +++++
 rtl/sram_port_arbiter.sv | 101 ++++++++++
 tb/tb_sram_port_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Bundle of the two requester ports, the program-mode strap and the SRAM
// port-0 pins for sram_port_arbiter. slave = arbiter side, master = the
// requesters plus SRAM macro side (testbench / enclosing SoC glue).
interface sram_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  localparam int MW = DW / 8;

  logic          prog_mode_i;

  logic          a_req_i;
  logic          a_we_i;
  logic [AW-1:0] a_addr_i;
  logic [DW-1:0] a_wdata_i;
  logic [MW-1:0] a_wmask_i;
  logic          a_gnt_o;
  logic          a_rvalid_o;
  logic [DW-1:0] a_rdata_o;

  logic          b_req_i;
  logic          b_we_i;
  logic [AW-1:0] b_addr_i;
  logic [DW-1:0] b_wdata_i;
  logic [MW-1:0] b_wmask_i;
  logic          b_gnt_o;
  logic          b_rvalid_o;
  logic [DW-1:0] b_rdata_o;

  logic          sram_csb_o;
  logic          sram_web_o;
  logic [MW-1:0] sram_wmask_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_din_o;
  logic [DW-1:0] sram_dout_i;

  modport slave (
    input  prog_mode_i,
    input  a_req_i, a_we_i, a_addr_i, a_wdata_i, a_wmask_i,
    output a_gnt_o, a_rvalid_o, a_rdata_o,
    input  b_req_i, b_we_i, b_addr_i, b_wdata_i, b_wmask_i,
    output b_gnt_o, b_rvalid_o, b_rdata_o,
    output sram_csb_o, sram_web_o, sram_wmask_o, sram_addr_o, sram_din_o,
    input  sram_dout_i
  );

  modport master (
    output prog_mode_i,
    output a_req_i, a_we_i, a_addr_i, a_wdata_i, a_wmask_i,
    input  a_gnt_o, a_rvalid_o, a_rdata_o,
    output b_req_i, b_we_i, b_addr_i, b_wdata_i, b_wmask_i,
    input  b_gnt_o, b_rvalid_o, b_rdata_o,
    input  sram_csb_o, sram_web_o, sram_wmask_o, sram_addr_o, sram_din_o,
    output sram_dout_i
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares port 0 (1rw) of a sky130 32x256 SRAM between
// requester A (programming / debug, priority) and requester B (TL-UL path).
// Grants and SRAM pin muxing are combinational; read data comes back one
// cycle later and is steered by the registered rd_owner state.
// Default build: fixed A priority with a MAX_BURST starvation guard for B.
// Define SRAM_ARB_RR_EN to replace the guard with round-robin on conflicts.
module sram_port_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  sram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {RD_NONE, RD_A, RD_B} rd_owner_e;

  rd_owner_e rd_owner;
  logic      a_gnt, b_gnt;
  logic      a_wins;

`ifdef SRAM_ARB_RR_EN
  logic last_b;  // 1: B won the last grant, so A wins the next conflict

  assign a_wins = last_b;

  // remember the most recent winner; reset to B so A wins the first conflict
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              last_b <= 1'b1;
    else if (a_gnt | b_gnt) last_b <= b_gnt;
  end
`else
  localparam logic [3:0] MAX_B = 4'(MAX_BURST);
  logic [3:0] burst_cnt;

  assign a_wins = (burst_cnt < MAX_B);

  // count A grants while B is kept waiting; any B grant or B idle restarts it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                             burst_cnt <= '0;
    else if (!bus.b_req_i || b_gnt)        burst_cnt <= '0;
    else if (a_gnt && !bus.prog_mode_i && burst_cnt < MAX_B)
                                           burst_cnt <= burst_cnt + 4'd1;
  end
`endif

  // grant selection; nothing is granted while reset is asserted
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst_i) begin
      if (bus.prog_mode_i) begin
        a_gnt = bus.a_req_i;
      end else if (bus.a_req_i && bus.b_req_i) begin
        a_gnt = a_wins;
        b_gnt = !a_wins;
      end else begin
        a_gnt = bus.a_req_i;
        b_gnt = bus.b_req_i;
      end
    end
  end

  assign bus.a_gnt_o = a_gnt;
  assign bus.b_gnt_o = b_gnt;

  // route the granted requester onto the SRAM pins; park at idle otherwise
  always_comb begin
    bus.sram_csb_o   = 1'b1;
    bus.sram_web_o   = 1'b1;
    bus.sram_addr_o  = '0;
    bus.sram_din_o   = '0;
    bus.sram_wmask_o = '0;
    if (a_gnt) begin
      bus.sram_csb_o   = 1'b0;
      bus.sram_web_o   = !bus.a_we_i;
      bus.sram_addr_o  = bus.a_addr_i;
      bus.sram_din_o   = bus.a_wdata_i;
      bus.sram_wmask_o = bus.a_wmask_i;
    end else if (b_gnt) begin
      bus.sram_csb_o   = 1'b0;
      bus.sram_web_o   = !bus.b_we_i;
      bus.sram_addr_o  = bus.b_addr_i;
      bus.sram_din_o   = bus.b_wdata_i;
      bus.sram_wmask_o = bus.b_wmask_i;
    end
  end

  // read-response owner: set by a granted read, lasts exactly one cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                     rd_owner <= RD_NONE;
    else if (a_gnt && !bus.a_we_i) rd_owner <= RD_A;
    else if (b_gnt && !bus.b_we_i) rd_owner <= RD_B;
    else                           rd_owner <= RD_NONE;
  end

  assign bus.a_rvalid_o = (rd_owner == RD_A);
  assign bus.b_rvalid_o = (rd_owner == RD_B);
  assign bus.a_rdata_o  = (rd_owner == RD_A) ? bus.sram_dout_i : '0;
  assign bus.b_rdata_o  = (rd_owner == RD_B) ? bus.sram_dout_i : '0;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model kept here.
module tb_sram_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.AW(AW), .DW(DW)) bus();

  sram_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // behavioural SRAM macro: masked write at the edge, read data next cycle
  logic [DW-1:0] sram_mem [0:255];
  always @(posedge clk) begin
    if (!bus.sram_csb_o) begin
      if (!bus.sram_web_o) begin
        for (int j = 0; j < MW; j++)
          if (bus.sram_wmask_o[j]) sram_mem[bus.sram_addr_o][8*j +: 8] <= bus.sram_din_o[8*j +: 8];
      end else begin
        bus.sram_dout_i <= sram_mem[bus.sram_addr_o];
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [0:255];
  int            a_run;      // A grants B has sat through in its current wait
  int            pend;       // whose read data is due now: 0 none, 1 A, 2 B
  logic [DW-1:0] pend_data;
  bit            rr_b_last;  // last winner was B
  // DUT observations captured at the most recent check
  logic rec_agnt, rec_bgnt, rec_arv, rec_brv;
  logic [DW-1:0] rec_ard, rec_brd;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int j = 0; j < MW; j++) if (m[j]) r[8*j +: 8] = nw[8*j +: 8];
    return r;
  endfunction

  task automatic check_cycle();
    bit ea, eb, we;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    logic [MW-1:0] wm;
    ea = 0; eb = 0;
    if (!rst) begin
      if (bus.prog_mode_i) ea = bus.a_req_i;
      else if (bus.a_req_i && bus.b_req_i) begin
`ifdef SRAM_ARB_RR_EN
        ea = rr_b_last;
`else
        ea = (a_run < MB);
`endif
        eb = !ea;
      end else begin
        ea = bus.a_req_i;
        eb = bus.b_req_i;
      end
    end
    we = 0; ad = '0; wd = '0; wm = '0;
    if (ea) begin we = bus.a_we_i; ad = bus.a_addr_i; wd = bus.a_wdata_i; wm = bus.a_wmask_i; end
    if (eb) begin we = bus.b_we_i; ad = bus.b_addr_i; wd = bus.b_wdata_i; wm = bus.b_wmask_i; end

    rec_agnt = bus.a_gnt_o; rec_bgnt = bus.b_gnt_o;
    rec_arv = bus.a_rvalid_o; rec_brv = bus.b_rvalid_o;
    rec_ard = bus.a_rdata_o;  rec_brd = bus.b_rdata_o;

    chk("a_gnt", bus.a_gnt_o, ea);
    chk("b_gnt", bus.b_gnt_o, eb);
    chk("csb", bus.sram_csb_o, !(ea || eb));
    chk("web", bus.sram_web_o, (ea || eb) ? !we : 1'b1);
    chk("addr", bus.sram_addr_o, ad);
    chk("din", bus.sram_din_o, wd);
    chk("wmask", bus.sram_wmask_o, wm);
    chk("a_rvalid", bus.a_rvalid_o, !rst && pend == 1);
    chk("b_rvalid", bus.b_rvalid_o, !rst && pend == 2);
    if (!rst && pend == 1) chk("a_rdata", bus.a_rdata_o, pend_data);
    if (!rst && pend == 2) chk("b_rdata", bus.b_rdata_o, pend_data);

    // advance the model to what should hold after the coming edge
    if (rst) begin
      a_run = 0; pend = 0; rr_b_last = 1;
    end else begin
      pend = 0;
      if ((ea || eb) && !we) begin
        pend = ea ? 1 : 2;
        pend_data = ref_mem[ad];
      end
      if ((ea || eb) && we) ref_mem[ad] = merge(ref_mem[ad], wd, wm);
      if (!bus.b_req_i || eb) a_run = 0;
      else if (ea && !bus.prog_mode_i && a_run < MB) a_run++;
      if (ea || eb) rr_b_last = eb;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input bit req, input bit we, input logic [AW-1:0] ad,
                       input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    bus.a_req_i = req; bus.a_we_i = we; bus.a_addr_i = ad; bus.a_wdata_i = wd; bus.a_wmask_i = wm;
  endtask

  task automatic set_b(input bit req, input bit we, input logic [AW-1:0] ad,
                       input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    bus.b_req_i = req; bus.b_we_i = we; bus.b_addr_i = ad; bus.b_wdata_i = wd; bus.b_wmask_i = wm;
  endtask

  task automatic idle();
    set_a(0, 0, '0, '0, '0);
    set_b(0, 0, '0, '0, '0);
  endtask

  initial begin
    bit prev;
    rst = 1'b1;
    bus.prog_mode_i = 1'b0;
    idle();
    a_run = 0; pend = 0; pend_data = '0; rr_b_last = 1;

    // reset held for three cycles, then idle after release
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // preload words 0..31 through A (word 1/2 get the interleave patterns)
    for (int i = 0; i < 32; i++) begin
      set_a(1, 1, AW'(i), (i == 1) ? 32'h1111_1111 : (i == 2) ? 32'h2222_2222 : $urandom, 4'hF);
      step();
    end
    idle();

    // A write 0xDEADBEEF to 0x10, then read it back
    set_a(1, 1, 8'h10, 32'hDEAD_BEEF, 4'hF);
    step();
    chk("wr_gnt", rec_agnt, 1'b1);
    set_a(1, 0, 8'h10, '0, '0);
    step();
    idle();
    step();
    chk("rd_rvalid", rec_arv, 1'b1);
    chk("rd_data", rec_ard, 32'hDEAD_BEEF);

    // both requesting continuously: starvation guard / round robin pattern
    set_a(1, 0, 8'h03, '0, '0);
    set_b(1, 0, 8'h04, '0, '0);
    for (int i = 0; i < 15; i++) begin
      step();
`ifdef SRAM_ARB_RR_EN
      if (i > 0) chk("rr_pat", rec_agnt, !prev);
`else
      chk("burst_pat", rec_agnt, (i % 5) != 4);
`endif
      prev = rec_agnt;
    end
    idle();
    step();

    // interleaved reads: A at n, B at n+1
    set_a(1, 0, 8'h01, '0, '0);
    step();
    idle();
    set_b(1, 0, 8'h02, '0, '0);
    step();
    chk("il_a_rv", rec_arv, 1'b1);
    chk("il_a_data", rec_ard, 32'h1111_1111);
    chk("il_b_rv_early", rec_brv, 1'b0);
    idle();
    step();
    chk("il_b_rv", rec_brv, 1'b1);
    chk("il_b_data", rec_brd, 32'h2222_2222);
    chk("il_a_rv_late", rec_arv, 1'b0);

    // program-mode lockout of B
    bus.prog_mode_i = 1'b1;
    set_b(1, 0, 8'h05, '0, '0);
    for (int i = 0; i < 20; i++) begin
      set_a((i % 4) == 1, 0, AW'(i), '0, '0);
      step();
      chk("lock_b_gnt", rec_bgnt, 1'b0);
    end
    set_a(0, 0, '0, '0, '0);
    bus.prog_mode_i = 1'b0;
    step();
    chk("unlock_b_gnt", rec_bgnt, 1'b1);
    idle();
    step();

    // reset asserted the cycle after a B read grant
    set_b(1, 0, 8'h02, '0, '0);
    step();
    idle();
    rst = 1'b1;
    step();
    chk("rst_b_rv", rec_brv, 1'b0);
    step();
    rst = 1'b0;
    repeat (3) begin
      step();
      chk("post_rst_rv", rec_arv | rec_brv, 1'b0);
    end

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(99) < 5) bus.prog_mode_i = !bus.prog_mode_i;
      if (!bus.a_req_i || rec_agnt)
        set_a($urandom_range(99) < 55, $urandom_range(1), AW'($urandom_range(31)), $urandom,
              MW'($urandom));
      if (!bus.b_req_i || rec_bgnt)
        set_b($urandom_range(99) < 60, $urandom_range(1), AW'($urandom_range(31)), $urandom,
              MW'($urandom));
      rec_agnt = 0; rec_bgnt = 0;
      step();
    end
    idle();
    bus.prog_mode_i = 1'b0;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
